// File: rtl/flow_pkg.sv
// Shared definitions for the valid/ready flow blocks: state encoding and default widths.
package flow_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int DWIDTH_8   = 8;
    localparam int DWIDTH_16  = 16;
    // One grant carries exactly the bytes of one packed output word.
    localparam int PACK_RATIO = 2;

endpackage

// File: rtl/rr_pick.sv
// Rotated-priority search: returns the first asserted request at or above ptr, wrapping.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    always_comb begin
        int idx;
        idx    = 0;
        gnt_id = '0;
        any    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                gnt_id = IDW'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/flow_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready stage between NREQ masters,
// locking each grant for a burst of BEATS handshakes.
module flow_rr_arbiter
    import flow_pkg::*;
#(
    parameter  int NREQ   = 4,
    parameter  int DWIDTH = DWIDTH_8,
    parameter  int BEATS  = PACK_RATIO,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_en,
    input  logic [NREQ-1:0]        src_val,
    output logic [NREQ-1:0]        src_rdy,
    input  logic [NREQ*DWIDTH-1:0] src_data,
    output logic                   dst_val,
    input  logic                   dst_rdy,
    output logic [DWIDTH-1:0]      dst_data,
    output logic                   grant_vld,
    output logic [IDW-1:0]         grant_id
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] pick_id;
    logic           pick_any;
    logic           beat;
    logic [IDW-1:0] ptr_next;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (src_val),
        .ptr    (ptr),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    // Pure pass-through while granted; nothing is buffered in the arbiter.
    always_comb begin
        src_rdy  = '0;
        dst_val  = 1'b0;
        dst_data = '0;
        if (state == BURST) begin
            dst_val           = src_val[grant_id];
            dst_data          = src_data[grant_id*DWIDTH +: DWIDTH];
            src_rdy[grant_id] = dst_rdy;
        end
    end

    assign beat     = dst_val & dst_rdy;
    assign ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            grant_vld <= 1'b0;
            grant_id  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_en && pick_any) begin
                        grant_id  <= pick_id;
                        grant_vld <= 1'b1;
                        cnt       <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    // The grant is held until the full burst is done, even if the
                    // granted source stalls or cfg_en drops meanwhile.
                    if (beat) begin
                        if (cnt == CW'(BEATS - 1)) begin
                            state     <= IDLE;
                            ptr       <= ptr_next;
                            cnt       <= '0;
                            grant_vld <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
